// File: rtl/tilemap_port_arbiter.sv
// Single-port tilemap RAM owner: copies the layout ROM into RAM, then serves renderer reads
// ahead of FIFO-buffered game-logic writes. Define TILEMAP_FWD_EN to forward pending writes to reads.
module tilemap_port_arbiter #(
  parameter int TILE_COUNT   = 300,
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          level_reload,
  output logic                          busy,
  input  logic                          rd_req,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  input  logic                          wr_req,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          starve_flag,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [DATA_W-1:0]             rom_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int INIT_W = $clog2(TILE_COUNT + 1);
  localparam int SC_W   = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  state_t                         state, state_nxt;
  logic [INIT_W-1:0]              init_cnt;
  logic                           init_last;
  wr_entry_t [FIFO_DEPTH-1:0]     fifo_q;
  logic [PTR_W-1:0]               wr_ptr, rd_ptr;
  logic [CNT_W-1:0]               count;
  logic                           push, pop;
  logic [SC_W-1:0]                starve_cnt;
  logic                           rd_vld_q, src_ram_q, fwd_hit_q;
  logic [DATA_W-1:0]              fwd_data_q;
  logic                           fwd_hit;
  logic [DATA_W-1:0]              fwd_data;

  assign init_last  = (init_cnt == INIT_W'(TILE_COUNT));
  assign fifo_count = count;
  assign wr_ready   = (state == S_RUN) && (count != CNT_W'(FIFO_DEPTH));
  // A reload discards the queue, so neither a push nor a pop may land that cycle.
  assign push       = wr_req && wr_ready && !level_reload;
  assign pop        = (state == S_RUN) && !rd_req && (count != '0) && !level_reload;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (!level_reload && init_last) state_nxt = S_RUN;
      S_RUN:   if (level_reload) state_nxt = S_INIT;
      default: state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    busy      = (state == S_INIT);
    rom_addr  = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_INIT: begin
        // ROM data lags its address by one cycle, so the write trails rom_addr by one.
        rom_addr = ADDR_W'(init_cnt);
        if (init_cnt != '0) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ADDR_W'(init_cnt - INIT_W'(1));
          mem_wdata = rom_data;
        end
      end
      S_RUN: begin
        if (rd_req) begin
          mem_en   = 1'b1;
          mem_addr = rd_addr;
        end else if (pop) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = fifo_q[rd_ptr].addr;
          mem_wdata = fifo_q[rd_ptr].data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || level_reload)           init_cnt <= '0;
    else if (state == S_INIT && !init_last) init_cnt <= init_cnt + INIT_W'(1);
  end

  // ---------------- write FIFO ----------------
  always_ff @(posedge clk) begin
    if (reset || level_reload) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= '{addr: wr_addr, data: wr_data};
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // ---------------- starvation monitor ----------------
  always_ff @(posedge clk) begin
    if (reset || level_reload) begin
      starve_cnt  <= '0;
      starve_flag <= 1'b0;
    end else if (pop) begin
      starve_cnt <= '0;
    end else if (state == S_RUN && count != '0 && starve_cnt != SC_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + SC_W'(1);
      if (starve_cnt == SC_W'(STARVE_LIMIT - 1)) starve_flag <= 1'b1;
    end
  end

  // ---------------- optional write-to-read forwarding ----------------
`ifdef TILEMAP_FWD_EN
  logic [PTR_W-1:0] fwd_idx;
  // Walk oldest to newest so the newest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      fwd_idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < count && fifo_q[fwd_idx].addr == rd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_q[fwd_idx].data;
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // ---------------- read return ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q   <= 1'b0;
      src_ram_q  <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      rd_vld_q   <= rd_req;
      src_ram_q  <= rd_req && (state == S_RUN);
      fwd_hit_q  <= rd_req && fwd_hit && !level_reload;
      fwd_data_q <= fwd_data;
    end
  end

  // Reads accepted during the copy return zero without touching the RAM.
  assign rd_valid = rd_vld_q;
  assign rd_data  = (rd_vld_q && src_ram_q) ? (fwd_hit_q ? fwd_data_q : mem_rdata) : '0;

endmodule

// File: tb/tb_tilemap_port_arbiter.sv
// Scoreboard bench for tilemap_port_arbiter: ROM/RAM models, read and commit queues checked by a monitor.
module tb_tilemap_port_arbiter;
  localparam int TILE_COUNT = 300;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 3;

  logic              clk = 1'b0;
  logic              reset, level_reload, busy;
  logic              rd_req, rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [2:0]        fifo_count;
  logic              starve_flag;
  logic [ADDR_W-1:0] rom_addr, mem_addr;
  logic [DATA_W-1:0] rom_data, mem_wdata, mem_rdata;
  logic              mem_en, mem_we;

  tilemap_port_arbiter dut (
    .clk(clk), .reset(reset), .level_reload(level_reload), .busy(busy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .fifo_count(fifo_count), .starve_flag(starve_flag),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Layout ROM: ROM[k] = k[2:0], one-cycle latency.
  always @(posedge clk) rom_data <= rom_addr[2:0];

  // Single-port write-first RAM.
  logic [DATA_W-1:0] ram [0:511];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        mem_rdata     <= mem_wdata;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  int                checks = 0;
  int                failures = 0;
  int                init_exp = 0;
  logic [DATA_W-1:0] exp_rd_q [$];
  wr_t               wr_q [$];
  logic [DATA_W-1:0] ref_map [0:TILE_COUNT-1];
  logic [DATA_W-1:0] mon_e;
  wr_t               mon_w;

  // Monitor: returned reads, committed writes and copy writes against the queues/ROM.
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_valid) begin
        checks++;
        if (exp_rd_q.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected got=%0h want=no_read", rd_data);
        end else begin
          mon_e = exp_rd_q.pop_front();
          if (rd_data !== mon_e) begin
            failures++;
            $display("FAIL rd_data got=%0h want=%0h", rd_data, mon_e);
          end
        end
      end
      if (mem_en && mem_we && busy) begin
        checks++;
        if (mem_addr !== 9'(init_exp) || mem_wdata !== mem_addr[2:0]) begin
          failures++;
          $display("FAIL init_write got=%0d:%0h want=%0d:%0h", mem_addr, mem_wdata, init_exp, 3'(init_exp));
        end
        init_exp++;
      end
      if (mem_en && !mem_we && busy) begin
        checks++;
        failures++;
        $display("FAIL init_ram_read got=%0d want=no_access", mem_addr);
      end
      if (mem_en && mem_we && !busy) begin
        checks++;
        if (wr_q.size() == 0) begin
          failures++;
          $display("FAIL commit_unexpected got=%0d:%0h want=none", mem_addr, mem_wdata);
        end else begin
          mon_w = wr_q.pop_front();
          if (mem_addr !== mon_w.addr || mem_wdata !== mon_w.data) begin
            failures++;
            $display("FAIL commit got=%0d:%0h want=%0d:%0h", mem_addr, mem_wdata, mon_w.addr, mon_w.data);
          end
          if (mem_addr < 9'(TILE_COUNT)) ref_map[mem_addr] = mem_wdata;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ref_rom();
    for (int k = 0; k < TILE_COUNT; k++) ref_map[k] = 3'(k);
  endtask

  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = ref_map[a];
`ifdef TILEMAP_FWD_EN
    foreach (wr_q[i]) if (wr_q[i].addr == a) v = wr_q[i].data;
`endif
    return v;
  endfunction

  // Expectation is taken before any same-cycle push is queued.
  task automatic do_read(input int a);
    rd_req  = 1'b1;
    rd_addr = 9'(a);
    exp_rd_q.push_back(exp_read(9'(a)));
  endtask

  task automatic do_write(input int a, input logic [DATA_W-1:0] d);
    wr_t w;
    wr_req  = 1'b1;
    wr_addr = 9'(a);
    wr_data = d;
    w.addr  = 9'(a);
    w.data  = d;
    wr_q.push_back(w);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      tick();
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL init_timeout got=busy want=idle");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; level_reload = 1'b0; rd_req = 1'b0; rd_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    tick(); tick();
    checks++;
    if ({rd_valid, rd_data, mem_en, mem_we, rom_addr, busy, wr_ready, starve_flag, fifo_count} !==
        {1'b0, 3'd0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL reset_state got=%b/%h/%b/%b/%0d/%b/%b/%b/%0d want=0/0/0/0/0/1/0/0/0",
               rd_valid, rd_data, mem_en, mem_we, rom_addr, busy, wr_ready, starve_flag, fifo_count);
    end
    init_exp = 0;
    reset = 1'b0;
  endtask

  task automatic test_init();
    int n;
    wait_init(n);
    checks++;
    if (n != 301) begin failures++; $display("FAIL init_len got=%0d want=301", n); end
    checks++;
    if (init_exp != TILE_COUNT) begin failures++; $display("FAIL init_count got=%0d want=300", init_exp); end
    set_ref_rom();
    do_read(5);
    tick();
    rd_req = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 3'b101) begin
      failures++;
      $display("FAIL first_read got=%b/%h want=1/5", rd_valid, rd_data);
    end
    tick();
  endtask

  task automatic test_read_priority();
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 10; i++) begin
      do_read(100 + i);
      if (i < 3) begin
        a = 9'(200 + i);
        do_write(200 + i, ~a[2:0]);
      end else wr_req = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0) begin failures++; $display("FAIL we_during_read got=1 want=0"); end
      tick();
    end
    rd_req = 1'b0; wr_req = 1'b0;
    checks++;
    if (fifo_count !== 3'd3) begin failures++; $display("FAIL count_after_reads got=%0d want=3", fifo_count); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 9'(200 + j)) begin
        failures++;
        $display("FAIL drain_order got=%b:%0d want=1:%0d", mem_we, mem_addr, 200 + j);
      end
      tick();
    end
    checks++;
    if (fifo_count !== 3'd0) begin failures++; $display("FAIL count_drained got=%0d want=0", fifo_count); end
    do_read(202);
    tick();
    rd_req = 1'b0;
    tick();
  endtask

  task automatic test_fifo_full();
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 4; i++) begin
      do_read(10 + i);
      a = 9'(220 + i);
      do_write(220 + i, ~a[2:0]);
      tick();
    end
    wr_req = 1'b0;
    checks++;
    if (fifo_count !== 3'd4 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL full got=%0d/%b want=4/0", fifo_count, wr_ready);
    end
    wr_req = 1'b1; wr_addr = 9'd230; wr_data = 3'b001;
    for (int i = 0; i < 2; i++) begin
      do_read(20 + i);
      @(negedge clk);
      checks++;
      if (wr_ready !== 1'b0) begin failures++; $display("FAIL full_hold got=%b want=0", wr_ready); end
      tick();
    end
    rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b0 || mem_we !== 1'b1) begin
      failures++;
      $display("FAIL pop_cycle got=%b/%b want=0/1", wr_ready, mem_we);
    end
    tick();
    do_read(30);
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1) begin failures++; $display("FAIL after_pop got=%b want=1", wr_ready); end
    do_write(230, 3'b001);
    tick();
    rd_req = 1'b0; wr_req = 1'b0;
    checks++;
    if (fifo_count !== 3'd4) begin failures++; $display("FAIL refill got=%0d want=4", fifo_count); end
    repeat (4) tick();
    checks++;
    if (fifo_count !== 3'd0 || starve_flag !== 1'b0) begin
      failures++;
      $display("FAIL full_drain got=%0d/%b want=0/0", fifo_count, starve_flag);
    end
  endtask

  task automatic test_starvation();
    int n;
    do_read(50);
    do_write(240, 3'b010);
    tick();
    wr_req = 1'b0;
    for (int i = 0; i < 63; i++) begin
      do_read(50 + (i % 8));
      tick();
    end
    checks++;
    if (starve_flag !== 1'b0) begin failures++; $display("FAIL starve_early got=1 want=0"); end
    do_read(60);
    tick();
    checks++;
    if (starve_flag !== 1'b1) begin failures++; $display("FAIL starve_set got=0 want=1"); end
    rd_req = 1'b0;
    tick(); tick();
    checks++;
    if (starve_flag !== 1'b1 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL starve_sticky got=%b/%0d want=1/0", starve_flag, fifo_count);
    end
    level_reload = 1'b1;
    init_exp = 0;
    tick();
    level_reload = 1'b0;
    checks++;
    if (starve_flag !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reload_clear got=%b/%b want=0/1", starve_flag, busy);
    end
    wait_init(n);
    checks++;
    if (init_exp != TILE_COUNT) begin failures++; $display("FAIL reinit_count got=%0d want=300", init_exp); end
    set_ref_rom();
  endtask

  task automatic test_forwarding();
    do_read(45);
    do_write(45, 3'b000);
    tick();
    do_read(45);
    do_write(45, 3'b011);
    tick();
    do_read(45);
    wr_req = 1'b0;
    checks++;
`ifdef TILEMAP_FWD_EN
    if (rd_data !== 3'b000) begin failures++; $display("FAIL fwd_read got=%h want=0", rd_data); end
`else
    if (rd_data !== 3'b101) begin failures++; $display("FAIL nofwd_read got=%h want=5", rd_data); end
`endif
    tick();
    rd_req = 1'b0;
    tick(); tick();
    do_read(45);
    tick();
    rd_req = 1'b0;
    tick();
    checks++;
    if (ref_map[45] !== 3'b011) begin failures++; $display("FAIL fwd_commit got=%h want=3", ref_map[45]); end
  endtask

  task automatic test_reload();
    int n;
    do_read(70);
    do_write(60, 3'b111);
    tick();
    do_read(71);
    do_write(61, 3'b111);
    tick();
    wr_req = 1'b0;
    level_reload = 1'b1;
    do_read(70);
    wr_q.delete();
    init_exp = 0;
    tick();
    level_reload = 1'b0;
    rd_req = 1'b0;
    checks++;
    if (fifo_count !== 3'd0 || busy !== 1'b1 || rom_addr !== 9'd0 || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL reload got=%0d/%b/%0d/%b want=0/1/0/1", fifo_count, busy, rom_addr, rd_valid);
    end
    rd_req = 1'b1; rd_addr = 9'd5;
    exp_rd_q.push_back(3'b000);
    tick();
    rd_req = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 3'b000) begin
      failures++;
      $display("FAIL init_read got=%b/%h want=1/0", rd_valid, rd_data);
    end
    wait_init(n);
    checks++;
    if (init_exp != TILE_COUNT) begin failures++; $display("FAIL reload_count got=%0d want=300", init_exp); end
    set_ref_rom();
    do_read(60);
    tick();
    rd_req = 1'b0;
    checks++;
    if (rd_data !== 3'b100) begin failures++; $display("FAIL discarded_write got=%h want=4", rd_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_init();
    test_read_priority();
    test_fifo_full();
    test_starvation();
    test_forwarding();
    test_reload();
    repeat (3) tick();
    checks++;
    if (exp_rd_q.size() != 0 || wr_q.size() != 0) begin
      failures++;
      $display("FAIL leftover got=%0d/%0d want=0/0", exp_rd_q.size(), wr_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
